// File: rtl/mem_arbiter_pkg.sv
// Shared encodings, default widths and small helpers for the memory arbiter.
package mem_arbiter_pkg;

  // Widths of the memory_unit command port.
  localparam int MEM_ADDR_W = 16;
  localparam int MEM_DATA_W = 32;

  // Cycles with ready held high before a command counts as a zero-latency completion.
  localparam int ACK_WINDOW_DEF = 4;

  // Arbiter state encodings (3-bit, kept as plain constants for legacy users).
  localparam logic [2:0] ARB_IDLE      = 3'd0;
  localparam logic [2:0] ARB_ISSUE     = 3'd1;
  localparam logic [2:0] ARB_WAIT_LOW  = 3'd2;
  localparam logic [2:0] ARB_WAIT_HIGH = 3'd3;
  localparam logic [2:0] ARB_DONE      = 3'd4;
  localparam logic [2:0] ARB_HOLD      = 3'd5;

  // Requester indices.
  localparam int REQ_MTU   = 0;
  localparam int REQ_EXEC  = 1;
  localparam int REQ_CELL  = 2;
  localparam int REQ_INCR  = 3;
  localparam int REQ_EQUAL = 4;

  // memory_unit command codes.
  typedef enum logic [1:0] {
    MEM_READ  = 2'd0,
    MEM_WRITE = 2'd1
  } mem_func_e;

  // Next round-robin index, wrapping n-1 back to 0.
  function automatic logic [2:0] wrap_inc(input logic [2:0] idx, input int n);
    return (int'(idx) >= n - 1) ? 3'd0 : idx + 3'd1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Rotating-priority encoder: first set request at or after the pointer, wrapping.
module mem_arbiter_rr_pick #(
  parameter int N     = 5,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  localparam int PW = IDX_W + 1;

  logic [PW-1:0] pos;
  logic          found;

  // Scan N positions starting at the pointer; the first hit wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    pos     = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr_i} + PW'(k);
      if (pos >= PW'(N)) begin
        pos = pos - PW'(N);
      end
      if (!found && req_i[pos[IDX_W-1:0]]) begin
        found                    = 1'b1;
        grant_o[pos[IDX_W-1:0]] = 1'b1;
        idx_o                    = pos[IDX_W-1:0];
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter in front of the single memory_unit port, with owner lock.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 5,
  parameter int ADDR_W     = MEM_ADDR_W,
  parameter int DATA_W     = MEM_DATA_W,
  parameter int ACK_WINDOW = ACK_WINDOW_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [2*NUM_REQ-1:0]      req_func,
  input  logic [ADDR_W*NUM_REQ-1:0] req_addr1,
  input  logic [ADDR_W*NUM_REQ-1:0] req_addr2,
  input  logic [DATA_W*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        done,
  output logic [2:0]                owner,
  input  logic                      mem_ready,
  output logic                      mem_execute,
  output logic [1:0]                mem_func,
  output logic [ADDR_W-1:0]         address1,
  output logic [ADDR_W-1:0]         address2,
  output logic [DATA_W-1:0]         write_data,
  output logic                      busy
);

  localparam int IDX_W = 3;
  localparam int CNT_W = $clog2(ACK_WINDOW + 1);

  logic [2:0]         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               exec_q, exec_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         func_q, func_d;
  logic [ADDR_W-1:0]  addr1_q, addr1_d;
  logic [ADDR_W-1:0]  addr2_q, addr2_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;

  logic               load_cmd;
  logic [IDX_W-1:0]   load_idx;

  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;

  // Per-requester views of the packed command buses.
  logic [1:0]         func_arr  [NUM_REQ];
  logic [ADDR_W-1:0]  addr1_arr [NUM_REQ];
  logic [ADDR_W-1:0]  addr2_arr [NUM_REQ];
  logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign func_arr[gi]  = req_func[2*gi +: 2];
      assign addr1_arr[gi] = req_addr1[ADDR_W*gi +: ADDR_W];
      assign addr2_arr[gi] = req_addr2[ADDR_W*gi +: ADDR_W];
      assign wdata_arr[gi] = req_wdata[DATA_W*gi +: DATA_W];
    end
  endgenerate

  mem_arbiter_rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  // Control FSM: arbitrate in IDLE, strobe once, follow the ready handshake, pulse done.
  // The WAIT_LOW window is checked one cycle after the counter reaches ACK_WINDOW,
  // so a memory that never drops ready completes 2+ACK_WINDOW cycles after grant.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    grant_d  = grant_q;
    done_d   = '0;
    exec_d   = 1'b0;
    cnt_d    = cnt_q;
    load_cmd = 1'b0;
    load_idx = owner_q;
    case (state_q)
      ARB_IDLE: begin
        if (mem_ready && pick_any) begin
          grant_d  = pick_grant;
          owner_d  = pick_idx;
          load_cmd = 1'b1;
          load_idx = pick_idx;
          exec_d   = 1'b1;
          state_d  = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        cnt_d   = '0;
        state_d = ARB_WAIT_LOW;
      end
      ARB_WAIT_LOW: begin
        if (!mem_ready) begin
          state_d = ARB_WAIT_HIGH;
        end else if (cnt_q == CNT_W'(ACK_WINDOW)) begin
          done_d  = grant_q;
          state_d = ARB_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ARB_WAIT_HIGH: begin
        if (mem_ready) begin
          done_d  = grant_q;
          state_d = ARB_DONE;
        end
      end
      ARB_DONE, ARB_HOLD: begin
        if (!req_lock[owner_q]) begin
          grant_d = '0;
          ptr_d   = wrap_inc(owner_q, NUM_REQ);
          state_d = ARB_IDLE;
        end else if (state_q == ARB_DONE) begin
          state_d = ARB_HOLD;
        end else if (req[owner_q] && mem_ready) begin
          load_cmd = 1'b1;
          exec_d   = 1'b1;
          state_d  = ARB_ISSUE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = ARB_IDLE;
      end
    endcase
  end

  // Command capture: the selected requester's slice is frozen until the next issue.
  always_comb begin
    func_d  = func_q;
    addr1_d = addr1_q;
    addr2_d = addr2_q;
    wdata_d = wdata_q;
    if (load_cmd) begin
      func_d  = func_arr[load_idx];
      addr1_d = addr1_arr[load_idx];
      addr2_d = addr2_arr[load_idx];
      wdata_d = wdata_arr[load_idx];
    end
  end

  // State and output registers; reset abandons any command in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      grant_q <= '0;
      done_q  <= '0;
      exec_q  <= 1'b0;
      cnt_q   <= '0;
      func_q  <= '0;
      addr1_q <= '0;
      addr2_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      exec_q  <= exec_d;
      cnt_q   <= cnt_d;
      func_q  <= func_d;
      addr1_q <= addr1_d;
      addr2_q <= addr2_d;
      wdata_q <= wdata_d;
    end
  end

  assign grant       = grant_q;
  assign done        = done_q;
  assign owner       = owner_q;
  assign mem_execute = exec_q;
  assign mem_func    = func_q;
  assign address1    = addr1_q;
  assign address2    = addr2_q;
  assign write_data  = wdata_q;
  assign busy        = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, corner sequences, random traffic.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int N    = 5;
  localparam int AW   = MEM_ADDR_W;
  localparam int DW   = MEM_DATA_W;
  localparam int ACKW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    req_lock = '0;
  logic [2*N-1:0]  req_func;
  logic [AW*N-1:0] req_addr1;
  logic [AW*N-1:0] req_addr2;
  logic [DW*N-1:0] req_wdata;
  logic [N-1:0]    grant;
  logic [N-1:0]    done;
  logic [2:0]      owner;
  logic            mem_ready = 1'b1;
  logic            mem_execute;
  logic [1:0]      mem_func;
  logic [AW-1:0]   address1;
  logic [AW-1:0]   address2;
  logic [DW-1:0]   write_data;
  logic            busy;

  logic [1:0]      cmd_func [N];
  logic [AW-1:0]   cmd_a1   [N];
  logic [AW-1:0]   cmd_a2   [N];
  logic [DW-1:0]   cmd_wd   [N];

  int checks = 0;
  int passes = 0;

  mem_arbiter #(
    .NUM_REQ    (N),
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .ACK_WINDOW (ACKW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_lock    (req_lock),
    .req_func    (req_func),
    .req_addr1   (req_addr1),
    .req_addr2   (req_addr2),
    .req_wdata   (req_wdata),
    .grant       (grant),
    .done        (done),
    .owner       (owner),
    .mem_ready   (mem_ready),
    .mem_execute (mem_execute),
    .mem_func    (mem_func),
    .address1    (address1),
    .address2    (address2),
    .write_data  (write_data),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Pack per-requester commands onto the DUT buses.
  always_comb begin
    req_func  = '0;
    req_addr1 = '0;
    req_addr2 = '0;
    req_wdata = '0;
    for (int i = 0; i < N; i++) begin
      req_func[2*i +: 2]   = cmd_func[i];
      req_addr1[AW*i +: AW] = cmd_a1[i];
      req_addr2[AW*i +: AW] = cmd_a2[i];
      req_wdata[DW*i +: DW] = cmd_wd[i];
    end
  end

  // Memory model: on a strobe, ready drops for mem_lat cycles (0 = never drops).
  int                mem_lat     = 0;
  bit                block_ready = 1'b0;
  int                lat_left    = 0;
  int                exec_count  = 0;
  logic [DW-1:0]     mem_model [int];

  always @(negedge clk) begin
    if (mem_execute) begin
      exec_count = exec_count + 1;
      if (mem_func == MEM_WRITE) mem_model[int'(address1)] = write_data;
      lat_left = mem_lat;
    end else if (lat_left > 0) begin
      lat_left = lat_left - 1;
    end
    mem_ready <= !block_ready && (lat_left == 0);
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // One clock; outputs sampled 1 time unit after the edge, with per-cycle invariants.
  task automatic tick();
    @(posedge clk);
    #1;
    chk("grant_onehot", 64'($countones(grant) <= 1), 64'(1));
    chk("busy_vs_grant", 64'(busy), 64'(grant != '0));
    if (mem_execute) chk("exec_no_done", 64'(done), 64'(0));
  endtask

  task automatic wait_grant(input int limit);
    int cyc;
    cyc = 0;
    while (grant == '0 && cyc < limit) begin
      tick();
      cyc++;
    end
    chk("grant_seen", 64'(grant != '0), 64'(1));
  endtask

  task automatic wait_done(input int limit, output int cyc);
    cyc = 0;
    while (done == '0 && cyc < limit) begin
      tick();
      cyc++;
    end
    chk("done_seen", 64'(done != '0), 64'(1));
  endtask

  task automatic rand_cmd(input int i);
    cmd_func[i] = 2'($urandom_range(0, 1));
    cmd_a1[i]   = AW'($urandom);
    cmd_a2[i]   = AW'($urandom);
    cmd_wd[i]   = DW'($urandom);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    req      = '0;
    req_lock = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_cmd(input string tag, input int idx);
    chk({tag, "_exec"},  64'(mem_execute), 64'(1));
    chk({tag, "_func"},  64'(mem_func),    64'(cmd_func[idx]));
    chk({tag, "_addr1"}, 64'(address1),    64'(cmd_a1[idx]));
    chk({tag, "_addr2"}, 64'(address2),    64'(cmd_a2[idx]));
    chk({tag, "_wdata"}, 64'(write_data),  64'(cmd_wd[idx]));
  endtask

  // Reference arbitration: first pending index at or after the pointer, modulo N.
  function automatic int rr_ref(input logic [N-1:0] r, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  // Reference completion time from grant: ready seen back high one edge later,
  // never sooner than 3; a memory that never drops ready takes 2+ACK_WINDOW.
  function automatic int exp_latency(input int lat);
    if (lat == 0) return ACKW + 2;
    return (lat + 1 < 3) ? 3 : lat + 1;
  endfunction

  typedef struct {
    logic [N-1:0] req;
    int           lat;
    logic [N-1:0] exp_grant;
    int           exp_owner;
    int           exp_lat;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int cyc;
    int ec;
    int ptr_m;
    int eo;
    int lat_opts [5];
    logic [N-1:0] nb;

    lat_opts = '{0, 2, 3, 4, 5};
    for (int i = 0; i < N; i++) rand_cmd(i);

    // Fresh pointer 0 at the start; pointer advances to owner+1 after each entry.
    vecs[0] = '{5'b00100, 2, 5'b00100, 2, 3};
    vecs[1] = '{5'b00011, 0, 5'b00001, 0, 6};
    vecs[2] = '{5'b10010, 3, 5'b00010, 1, 4};
    vecs[3] = '{5'b10001, 0, 5'b10000, 4, 6};
    vecs[4] = '{5'b11000, 4, 5'b01000, 3, 5};
    vecs[5] = '{5'b01111, 2, 5'b00001, 0, 3};
    vecs[6] = '{5'b10100, 0, 5'b00100, 2, 6};

    // Reset values.
    do_reset();
    chk("rst_grant", 64'(grant), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_owner", 64'(owner), 64'(0));
    chk("rst_exec", 64'(mem_execute), 64'(0));
    chk("rst_func", 64'(mem_func), 64'(0));
    chk("rst_addr1", 64'(address1), 64'(0));
    chk("rst_addr2", 64'(address2), 64'(0));
    chk("rst_wdata", 64'(write_data), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));

    // All five requesting from reset: served 0,1,2,3,4.
    mem_lat = 2;
    ec = exec_count;
    req = 5'b11111;
    for (int k = 0; k < N; k++) begin
      wait_grant(20);
      chk("all5_grant", 64'(grant), 64'(5'(1) << k));
      chk("all5_owner", 64'(owner), 64'(k));
      chk_cmd("all5", k);
      wait_done(30, cyc);
      chk("all5_done", 64'(done), 64'(5'(1) << k));
      $display("txn all5: owner %0d latency %0d", owner, cyc);
      req[k] = 1'b0;
      tick();
      chk("all5_idle", 64'(grant), 64'(0));
    end
    chk("all5_execs", 64'(exec_count - ec), 64'(5));

    // Vector table from a fresh reset.
    do_reset();
    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < N; i++) rand_cmd(i);
      if (v == 0) begin
        cmd_func[2] = MEM_WRITE;
        cmd_a1[2]   = AW'(16'h0010);
        cmd_wd[2]   = DW'(32'h00AB);
      end
      mem_lat = vecs[v].lat;
      ec = exec_count;
      req = vecs[v].req;
      wait_grant(20);
      chk("tbl_grant", 64'(grant), 64'(vecs[v].exp_grant));
      chk("tbl_owner", 64'(owner), 64'(vecs[v].exp_owner));
      chk_cmd("tbl", vecs[v].exp_owner);
      wait_done(30, cyc);
      chk("tbl_done", 64'(done), 64'(vecs[v].exp_grant));
      chk("tbl_latency", 64'(cyc), 64'(vecs[v].exp_lat));
      chk("tbl_execs", 64'(exec_count - ec), 64'(1));
      $display("txn table %0d: owner %0d latency %0d", v, owner, cyc);
      req = '0;
      tick();
      chk("tbl_idle", 64'(grant), 64'(0));
      if (v == 0) chk("mem_rdback_10", 64'(mem_model[16]), 64'(32'h00AB));
    end

    // Lock: requester 3 runs a read then a write while requester 0 waits.
    mem_lat = 2;
    cmd_func[3] = MEM_READ;  cmd_a1[3] = AW'(16'h0020);
    cmd_func[0] = MEM_WRITE; cmd_a1[0] = AW'(16'h0030);
    req = 5'b01000;
    req_lock = 5'b01000;
    wait_grant(20);
    chk("lock_grant1", 64'(grant), 64'(5'b01000));
    chk_cmd("lock_cmd1", 3);
    req[0] = 1'b1;
    wait_done(30, cyc);
    chk("lock_done1", 64'(done), 64'(5'b01000));
    $display("txn lock read: owner %0d latency %0d", owner, cyc);
    cmd_func[3] = MEM_WRITE; cmd_a1[3] = AW'(16'h0021); cmd_wd[3] = DW'(32'h005A);
    cyc = 0;
    tick();
    while (!mem_execute && cyc < 20) begin
      chk("lock_hold_grant", 64'(grant), 64'(5'b01000));
      tick();
      cyc++;
    end
    chk("lock_grant2", 64'(grant), 64'(5'b01000));
    chk_cmd("lock_cmd2", 3);
    wait_done(30, cyc);
    chk("lock_done2", 64'(done), 64'(5'b01000));
    $display("txn lock write: owner %0d latency %0d", owner, cyc);
    req[3] = 1'b0;
    req_lock[3] = 1'b0;
    cyc = 0;
    tick();
    while ((grant == '0 || grant == 5'b01000) && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("lock_next_grant", 64'(grant), 64'(5'b00001));
    chk_cmd("lock_cmd0", 0);
    wait_done(30, cyc);
    chk("lock_done0", 64'(done), 64'(5'b00001));
    chk("mem_rdback_21", 64'(mem_model[16'h21]), 64'(32'h005A));
    $display("txn lock follow-on: owner %0d latency %0d", owner, cyc);
    req = '0;
    tick();

    // Reset while waiting for ready to return: abandoned, pointer back to 0.
    mem_lat = 5;
    req = 5'b00010;
    wait_grant(20);
    chk("rstw_grant", 64'(grant), 64'(5'b00010));
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("rstw_grant0", 64'(grant), 64'(0));
    chk("rstw_exec0", 64'(mem_execute), 64'(0));
    chk("rstw_busy0", 64'(busy), 64'(0));
    chk("rstw_done0", 64'(done), 64'(0));
    rst = 1'b0;
    req = '0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("rstw_no_done", 64'(done), 64'(0));
    end
    mem_lat = 2;
    req = 5'b00011;
    wait_grant(20);
    chk("rstw_ptr0_grant", 64'(grant), 64'(5'b00001));
    wait_done(30, cyc);
    $display("txn after reset: owner %0d latency %0d", owner, cyc);
    req = '0;
    tick();

    // Ready low in IDLE blocks arbitration until it rises.
    block_ready = 1'b1;
    tick();
    tick();
    req = 5'b00001;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("nready_no_grant", 64'(grant), 64'(0));
    end
    block_ready = 1'b0;
    tick();
    chk("nready_grant", 64'(grant), 64'(5'b00001));
    wait_done(30, cyc);
    $display("txn ready-gated: owner %0d latency %0d", owner, cyc);
    req = '0;
    tick();

    // Randomized traffic against the reference arbitration and latency rules.
    do_reset();
    ptr_m = 0;
    for (int t = 0; t < 40; t++) begin
      nb = N'($urandom_range(0, 31)) & ~req;
      if ((req | nb) == '0) nb = N'(1) << $urandom_range(0, N - 1);
      for (int i = 0; i < N; i++) if (nb[i]) rand_cmd(i);
      req = req | nb;
      mem_lat = lat_opts[$urandom_range(0, 4)];
      eo = rr_ref(req, ptr_m);
      ec = exec_count;
      wait_grant(20);
      chk("rnd_grant", 64'(grant), 64'(5'(1) << eo));
      chk("rnd_owner", 64'(owner), 64'(eo));
      chk_cmd("rnd", eo);
      wait_done(30, cyc);
      chk("rnd_done", 64'(done), 64'(5'(1) << eo));
      chk("rnd_latency", 64'(cyc), 64'(exp_latency(mem_lat)));
      chk("rnd_execs", 64'(exec_count - ec), 64'(1));
      $display("txn rnd %0d: req %b owner %0d lat %0d cycles %0d", t, req, eo, mem_lat, cyc);
      req[eo] = 1'b0;
      ptr_m = (eo + 1) % N;
      tick();
      chk("rnd_idle", 64'(grant), 64'(0));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
